// File: rtl/nubus_master_sched.sv
// nubus_master_sched
//   Shares one NuBus master controller between NREQ local requesters.
//   A round-robin pick selects one requester. The block then raises cpu_valid/cpu_lock
//   toward the master. It also runs the distributed ARB[3:0] contention, using a settle
//   timer to produce arb_grant. Master ownership is tracked to completion. The selected
//   requester then gets a done pulse, or a done+err pulse if the watchdog expires.
// Ports
//   nub_clkn, reset        : clock (rising edge), async active-high reset
//   req_i, lock_i          : per-requester level request / locked-transaction flag
//   gnt_o, done_o, err_o   : one-hot grant, completion pulse, timeout pulse
//   cpu_valid_o/lock_o     : request to the master controller
//   arb_grant_o            : contention won and settled
//   arbcy_i, owner_i       : master status (arbitrating / owns bus)
//   card_id_i, nub_arbn_i  : slot ID, sampled active-low ARB lines
//   arb_drv_o, rqst_drv_o  : 1 = pull the corresponding open-collector line low
module nubus_master_sched #(
    parameter int NREQ       = 4,
    parameter int ARB_SETTLE = 2,
    parameter int TMO_W      = 8
) (
    input  logic            nub_clkn,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] lock_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [NREQ-1:0] done_o,
    output logic            err_o,
    output logic            cpu_valid_o,
    output logic            cpu_lock_o,
    output logic            arb_grant_o,
    input  logic            arbcy_i,
    input  logic            owner_i,
    input  logic [3:0]      card_id_i,
    input  logic [3:0]      nub_arbn_i,
    output logic [3:0]      arb_drv_o,
    output logic            rqst_drv_o
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ARB_SETTLE + 1);
    localparam logic [CW-1:0]    SETTLE_MAX = CW'(ARB_SETTLE);
    // Fires one count early so err_o is visible in the cycle the counter reaches all-ones.
    localparam logic [TMO_W-1:0] WD_LAST    = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [NREQ-1:0]  ONE        = NREQ'(1);
    localparam logic [SW-1:0]    PTR_RST    = SW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ARB, OWN, XFER} state_t;

    state_t           state;
    logic [SW-1:0]    sel;
    logic [SW-1:0]    ptr;
    logic [TMO_W-1:0] wdog;
    logic [CW-1:0]    settle;

    logic             busy;
    logic             win;
    logic             pick_vld;
    logic [SW-1:0]    pick_idx;
    logic [SW-1:0]    cand;
    logic             kill;

    assign busy = (state != IDLE);

    // Round-robin search ptr+1, ptr+2, ... wrapping. Walking from farthest to nearest
    // lets the nearest requesting candidate win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = SW'((int'(ptr) + i) % NREQ);
            if (req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Distributed contention. Every lower ID bit is released once a higher line is
    // asserted by someone else while our own ID bit there is 0. Drive is also gated by
    // busy so that reset or IDLE drops the lines immediately.
    always_comb begin
        kill      = 1'b0;
        arb_drv_o = '0;
        for (int k = 3; k >= 0; k--) begin
            arb_drv_o[k] = busy & arbcy_i & card_id_i[k] & ~kill;
            kill         = kill | (~nub_arbn_i[k] & ~card_id_i[k]);
        end
    end

    assign win         = (~nub_arbn_i == card_id_i);
    assign arb_grant_o = busy & arbcy_i & (settle == SETTLE_MAX) & win;
    assign rqst_drv_o  = arbcy_i & ~owner_i & (state == ARB);

    // Settle timer: restarts on every arbcy_i drop, saturates once the lines are trusted.
    always_ff @(posedge nub_clkn or posedge reset) begin
        if (reset)
            settle <= '0;
        else if (!arbcy_i)
            settle <= '0;
        else if (settle != SETTLE_MAX)
            settle <= settle + 1'b1;
    end

    always_ff @(posedge nub_clkn or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            ptr         <= PTR_RST;
            wdog        <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            cpu_valid_o <= 1'b0;
            cpu_lock_o  <= 1'b0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            if (state == IDLE) begin
                wdog <= '0;
                if (pick_vld) begin
                    sel         <= pick_idx;
                    gnt_o       <= ONE << pick_idx;
                    cpu_valid_o <= 1'b1;
                    cpu_lock_o  <= lock_i[pick_idx];
                    state       <= ARB;
                end
            end else if (wdog == WD_LAST) begin
                // Watchdog: abandon the transaction and report it to the owner.
                err_o       <= 1'b1;
                done_o      <= ONE << sel;
                gnt_o       <= '0;
                cpu_valid_o <= 1'b0;
                cpu_lock_o  <= 1'b0;
                ptr         <= sel;
                wdog        <= '0;
                state       <= IDLE;
            end else begin
                wdog <= wdog + 1'b1;
                case (state)
                    ARB: begin
                        if (arbcy_i && arb_grant_o)
                            state <= OWN;
                    end
                    OWN: begin
                        // cpu_valid drops here so the master cannot re-arbitrate back to back.
                        if (owner_i) begin
                            cpu_valid_o <= 1'b0;
                            state       <= XFER;
                        end
                    end
                    XFER: begin
                        // owner_i was 1 on entry, so a low level here is the 1->0 edge.
                        if (!owner_i) begin
                            done_o     <= ONE << sel;
                            gnt_o      <= '0;
                            cpu_lock_o <= 1'b0;
                            ptr        <= sel;
                            wdog       <= '0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nubus_master_sched.sv
module tb_nubus_master_sched;

    logic       nub_clkn = 1'b0;
    logic       reset;
    logic [3:0] req_i, lock_i, gnt_o, done_o;
    logic       err_o, cpu_valid_o, cpu_lock_o, arb_grant_o;
    logic       arbcy_i, owner_i;
    logic [3:0] card_id_i, nub_arbn_i, arb_drv_o;
    logic       rqst_drv_o;

    int checks = 0;
    int errors = 0;

    wire [16:0] outs = {gnt_o, done_o, err_o, cpu_valid_o, cpu_lock_o, arb_grant_o,
                        arb_drv_o, rqst_drv_o};

    nubus_master_sched #(.NREQ(4), .ARB_SETTLE(2), .TMO_W(8)) dut (
        .nub_clkn(nub_clkn), .reset(reset), .req_i(req_i), .lock_i(lock_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .cpu_valid_o(cpu_valid_o),
        .cpu_lock_o(cpu_lock_o), .arb_grant_o(arb_grant_o), .arbcy_i(arbcy_i),
        .owner_i(owner_i), .card_id_i(card_id_i), .nub_arbn_i(nub_arbn_i),
        .arb_drv_o(arb_drv_o), .rqst_drv_o(rqst_drv_o)
    );

    always #5 nub_clkn = ~nub_clkn;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge nub_clkn);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_i = '0; lock_i = '0; arbcy_i = 1'b0; owner_i = 1'b0;
        nub_arbn_i = 4'hF;
        tick(2);
        reset = 1'b0;
    endtask

    // Drives a winning arbitration and a full ownership cycle from state ARB.
    task automatic run_bus();
        arbcy_i = 1'b1; nub_arbn_i = ~card_id_i;
        tick(3);
        arbcy_i = 1'b0; nub_arbn_i = 4'hF; owner_i = 1'b1;
        tick();
        owner_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        card_id_i = 4'hA;
        apply_reset();
        reset = 1'b1;
        #1;
        checks++; if (outs !== 17'd0) begin errors++; $display("FAIL reset_idle: got %b exp 0", outs); end
        req_i = 4'hF; arbcy_i = 1'b1;
        tick(2);
        checks++; if (outs !== 17'd0) begin errors++; $display("FAIL reset_held: got %b exp 0", outs); end
        req_i = '0; arbcy_i = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        card_id_i = 4'hA;
        req_i = 4'b0001;
        tick();
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b exp 0001", gnt_o); end
        checks++; if ({cpu_valid_o, cpu_lock_o} !== 2'b10) begin errors++; $display("FAIL basic_valid: got %b exp 10", {cpu_valid_o, cpu_lock_o}); end
        arbcy_i = 1'b1; nub_arbn_i = 4'h5;
        #1;
        checks++; if ({arb_drv_o, rqst_drv_o, arb_grant_o} !== 6'b1010_1_0) begin errors++; $display("FAIL basic_drv: got %b exp 101010", {arb_drv_o, rqst_drv_o, arb_grant_o}); end
        tick();
        checks++; if (arb_grant_o !== 1'b0) begin errors++; $display("FAIL basic_settle1: got %b exp 0", arb_grant_o); end
        tick();
        checks++; if (arb_grant_o !== 1'b1) begin errors++; $display("FAIL basic_settle2: got %b exp 1", arb_grant_o); end
        tick();
        arbcy_i = 1'b0; nub_arbn_i = 4'hF; owner_i = 1'b1;
        #1;
        checks++; if ({cpu_valid_o, rqst_drv_o} !== 2'b10) begin errors++; $display("FAIL basic_own: got %b exp 10", {cpu_valid_o, rqst_drv_o}); end
        tick();
        checks++; if ({cpu_valid_o, gnt_o, done_o} !== 9'b0_0001_0000) begin errors++; $display("FAIL basic_xfer: got %b exp 000010000", {cpu_valid_o, gnt_o, done_o}); end
        owner_i = 1'b0; req_i = '0;
        tick();
        checks++; if ({done_o, gnt_o, err_o} !== 9'b0001_0000_0) begin errors++; $display("FAIL basic_done: got %b exp 000100000", {done_o, gnt_o, err_o}); end
        tick();
        checks++; if (done_o !== 4'b0000) begin errors++; $display("FAIL basic_pulse: got %b exp 0000", done_o); end
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        apply_reset();
        card_id_i = 4'hA;
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << order[i];
            tick();
            checks++; if (gnt_o !== e) begin errors++; $display("FAIL rr_gnt%0d: got %b exp %b", i, gnt_o, e); end
            run_bus();
            checks++; if ({done_o, gnt_o} !== {e, 4'b0000}) begin errors++; $display("FAIL rr_done%0d: got %b exp %b", i, {done_o, gnt_o}, {e, 4'b0000}); end
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_contention();
        card_id_i = 4'h5;
        req_i = 4'b0001;
        tick();
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL cont_gnt: got %b exp 0001", gnt_o); end
        arbcy_i = 1'b1; nub_arbn_i = 4'hF;
        #1;
        checks++; if (arb_drv_o !== 4'b0101) begin errors++; $display("FAIL cont_drv_free: got %b exp 0101", arb_drv_o); end
        nub_arbn_i = 4'h3;
        #1;
        checks++; if (arb_drv_o !== 4'b0000) begin errors++; $display("FAIL cont_drv_lose: got %b exp 0000", arb_drv_o); end
        tick(3);
        checks++; if ({arb_grant_o, rqst_drv_o} !== 2'b01) begin errors++; $display("FAIL cont_lost: got %b exp 01", {arb_grant_o, rqst_drv_o}); end
        arbcy_i = 1'b0;
        tick();
        arbcy_i = 1'b1; nub_arbn_i = 4'hA;
        #1;
        checks++; if ({arb_drv_o, arb_grant_o} !== 5'b0101_0) begin errors++; $display("FAIL cont_restart: got %b exp 01010", {arb_drv_o, arb_grant_o}); end
        tick();
        checks++; if (arb_grant_o !== 1'b0) begin errors++; $display("FAIL cont_settle1: got %b exp 0", arb_grant_o); end
        tick();
        checks++; if (arb_grant_o !== 1'b1) begin errors++; $display("FAIL cont_win: got %b exp 1", arb_grant_o); end
        tick();
        arbcy_i = 1'b0; nub_arbn_i = 4'hF; owner_i = 1'b1;
        tick();
        owner_i = 1'b0; req_i = '0;
        tick();
        checks++; if (done_o !== 4'b0001) begin errors++; $display("FAIL cont_done: got %b exp 0001", done_o); end
        tick();
    endtask

    task automatic test_lock();
        card_id_i = 4'hA;
        req_i = 4'b0100; lock_i = 4'b0100;
        tick();
        checks++; if ({gnt_o, cpu_valid_o, cpu_lock_o} !== 6'b0100_11) begin errors++; $display("FAIL lock_pick: got %b exp 010011", {gnt_o, cpu_valid_o, cpu_lock_o}); end
        req_i = '0; lock_i = '0;
        arbcy_i = 1'b1; nub_arbn_i = 4'h5;
        tick(3);
        checks++; if (cpu_lock_o !== 1'b1) begin errors++; $display("FAIL lock_own: got %b exp 1", cpu_lock_o); end
        arbcy_i = 1'b0; nub_arbn_i = 4'hF; owner_i = 1'b1;
        tick();
        checks++; if ({cpu_valid_o, cpu_lock_o, gnt_o} !== 6'b01_0100) begin errors++; $display("FAIL lock_xfer: got %b exp 010100", {cpu_valid_o, cpu_lock_o, gnt_o}); end
        owner_i = 1'b0;
        tick();
        checks++; if ({done_o, cpu_lock_o, gnt_o} !== 9'b0100_0_0000) begin errors++; $display("FAIL lock_done: got %b exp 010000000", {done_o, cpu_lock_o, gnt_o}); end
        tick();
    endtask

    task automatic test_timeout();
        req_i = 4'b0010;
        tick();
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL tmo_pick: got %b exp 0010", gnt_o); end
        req_i = '0;
        tick(254);
        checks++; if ({err_o, gnt_o} !== 5'b0_0010) begin errors++; $display("FAIL tmo_early: got %b exp 00010", {err_o, gnt_o}); end
        tick();
        checks++; if ({err_o, done_o, gnt_o, cpu_valid_o} !== 10'b1_0010_0000_0) begin errors++; $display("FAIL tmo_fire: got %b exp 1001000000", {err_o, done_o, gnt_o, cpu_valid_o}); end
        req_i = 4'b1000;
        tick();
        checks++; if ({err_o, done_o, gnt_o} !== 9'b0_0000_1000) begin errors++; $display("FAIL tmo_next: got %b exp 000001000", {err_o, done_o, gnt_o}); end
        req_i = '0;
    endtask

    task automatic test_reset_mid();
        arbcy_i = 1'b1; nub_arbn_i = 4'h5;
        tick(3);
        arbcy_i = 1'b0; nub_arbn_i = 4'hF; owner_i = 1'b1;
        tick();
        checks++; if ({gnt_o, cpu_valid_o} !== 5'b1000_0) begin errors++; $display("FAIL rst_xfer: got %b exp 10000", {gnt_o, cpu_valid_o}); end
        arbcy_i = 1'b1;
        #1;
        checks++; if (arb_drv_o !== 4'b1010) begin errors++; $display("FAIL rst_pre_drv: got %b exp 1010", arb_drv_o); end
        #1 reset = 1'b1;
        #1;
        checks++; if (outs !== 17'd0) begin errors++; $display("FAIL rst_async: got %b exp 0", outs); end
        #1 reset = 1'b0;
        arbcy_i = 1'b0; owner_i = 1'b0; req_i = 4'b1111;
        tick();
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rst_restart: got %b exp 0001", gnt_o); end
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
